// File: rtl/sram_like_responder.sv
// SRAM-style responder: a two-deep in-order request queue in front of a
// byte-enabled 32-bit memory, completing each request after a fixed latency.
module sram_like_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_ok,
    output logic        data_ok
);

    localparam int         DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [2:0] COUNT_INIT = 3'(LATENCY - 1);

    typedef struct packed {
        logic                  wr;
        logic [1:0]            size;
        logic [ADDR_WIDTH-1:0] index;
        logic [1:0]            offset;
        logic [31:0]           wdata;
        logic [2:0]            count;
    } entry_t;

    entry_t      slot [2];
    logic [1:0]  valid;
    entry_t      aged [2];
    entry_t      incoming;
    logic        full;
    logic        push;
    logic        pop;
    logic [3:0]  byte_en;
    logic [31:0] mem [DEPTH];

    // Address bits above the memory index alias onto the same words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

    // Slot 0 is always the head; valid[1] implies valid[0].
    assign full    = valid[1];
    assign addr_ok = req && !full && !rst;
    assign push    = addr_ok;
    assign data_ok = !rst && valid[0] && (slot[0].count == 3'd0);
    assign pop     = data_ok;

    always_comb begin
        incoming.wr     = wr;
        incoming.size   = size;
        incoming.index  = addr[ADDR_WIDTH+1:2];
        incoming.offset = addr[1:0];
        incoming.wdata  = wdata;
        incoming.count  = COUNT_INIT;
        for (int i = 0; i < 2; i++) begin
            aged[i] = slot[i];
            if (slot[i].count != 3'd0) begin
                aged[i].count = slot[i].count - 3'd1;
            end
        end
    end

    // Every pending entry keeps counting down, so a younger request that has
    // already waited out its latency completes right after the head pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 2'b00;
        end else begin
            unique case ({pop, push})
                2'b11: begin
                    slot[0] <= incoming;
                    valid   <= 2'b01;
                end
                2'b10: begin
                    slot[0] <= aged[1];
                    valid   <= {1'b0, valid[1]};
                end
                2'b01: begin
                    if (!valid[0]) begin
                        slot[0] <= incoming;
                        valid   <= 2'b01;
                    end else begin
                        slot[0] <= aged[0];
                        slot[1] <= incoming;
                        valid   <= 2'b11;
                    end
                end
                default: begin
                    slot[0] <= aged[0];
                    slot[1] <= aged[1];
                end
            endcase
        end
    end

    always_comb begin
        byte_en = 4'b0000;
        unique case (slot[0].size)
            2'd0:    byte_en[slot[0].offset] = 1'b1;
            2'd1:    byte_en = slot[0].offset[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Memory has no reset; a write commits only at the end of its data_ok cycle.
    always_ff @(posedge clk) begin
        if (data_ok && slot[0].wr) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[slot[0].index][8*b +: 8] <= slot[0].wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = (data_ok && !slot[0].wr) ? mem[slot[0].index] : 32'd0;

endmodule

// File: tb/tb_sram_like_responder.sv
// Randomised scoreboard bench for sram_like_responder: the driver predicts
// acceptance and completion cycles, the monitor checks each completion.
module tb_sram_like_responder;

    localparam int AW  = 10;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    sram_like_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .wr     (wr),
        .size   (size),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .addr_ok(addr_ok),
        .data_ok(data_ok)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } pend_t;

    pend_t       sb[$];
    int          done_cycles[$];
    int          last_due = -1;
    logic [31:0] ref_mem [1 << AW];
    logic [3:0]  ref_def [1 << AW];
    int          checks = 0;
    int          failures = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h",
                     name, cyc, actual, expected);
        end
    endtask

    function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    return 4'b0001 << off;
            2'd1:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Monitor: every completion pops the oldest expectation; memory contents
    // of the model change only when a write actually completes.
    always @(negedge clk) begin
        pend_t       e;
        int          idx;
        logic [3:0]  be;
        logic [31:0] m;
        if (data_ok === 1'b1) begin
            if (sb.size() == 0) begin
                check_output("spurious_data_ok", {31'd0, data_ok}, 32'd0);
            end else begin
                e   = sb.pop_front();
                idx = int'(e.addr[AW+1:2]);
                be  = lanes(e.size, e.addr[1:0]);
                check_output("data_ok_cycle", cyc, e.due);
                if (e.wr) begin
                    check_output("write_rdata_zero", rdata, 32'd0);
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) begin
                            ref_mem[idx][8*b +: 8] = e.wdata[8*b +: 8];
                        end
                    end
                    ref_def[idx] = ref_def[idx] | be;
                end else begin
                    m = {{8{ref_def[idx][3]}}, {8{ref_def[idx][2]}},
                         {8{ref_def[idx][1]}}, {8{ref_def[idx][0]}}};
                    check_output("read_data", rdata & m, ref_mem[idx] & m);
                end
            end
        end else begin
            check_output("rdata_idle", rdata, 32'd0);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                check_output("missing_data_ok", {31'd0, data_ok}, 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic apply_stimulus(input logic r_rst, input logic r_req, input logic r_wr,
                                  input logic [1:0] r_size, input logic [31:0] r_addr,
                                  input logic [31:0] r_wdata, output logic accepted);
        logic exp_ok;
        int   due;
        @(posedge clk);
        #1;
        rst   = r_rst;
        req   = r_req;
        wr    = r_wr;
        size  = r_size;
        addr  = r_addr;
        wdata = r_wdata;
        if (r_rst) begin
            sb.delete();
            done_cycles.delete();
            last_due = -1;
        end
        @(negedge clk);
        while (done_cycles.size() > 0 && done_cycles[0] < cyc) begin
            void'(done_cycles.pop_front());
        end
        exp_ok = !r_rst && r_req && (done_cycles.size() < 2);
        check_output("addr_ok", {31'd0, addr_ok}, {31'd0, exp_ok});
        accepted = exp_ok;
        if (exp_ok) begin
            due      = (cyc + LAT > last_due + 1) ? cyc + LAT : last_due + 1;
            last_due = due;
            done_cycles.push_back(due);
            sb.push_back('{due, r_wr, r_size, r_addr, r_wdata});
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, acc);
    endtask

    task automatic reset_for(input int n);
        logic acc;
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 2'd2, 32'd0, 32'd0, acc);
    endtask

    // Holds req high until the request is taken, as an initiator would.
    task automatic send(input logic s_wr, input logic [1:0] s_size,
                        input logic [31:0] s_addr, input logic [31:0] s_wdata);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 10) begin
            apply_stimulus(1'b0, 1'b1, s_wr, s_size, s_addr, s_wdata, acc);
            tries++;
        end
        if (!acc) check_output("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic        acc;
        logic [31:0] a;
        int          drain;
        for (int i = 0; i < (1 << AW); i++) begin
            ref_mem[i] = 32'd0;
            ref_def[i] = 4'b0000;
        end

        reset_for(2);

        // Word write then read back
        send(1'b1, 2'd2, 32'h40, 32'hDEADBEEF);
        idle(2);
        send(1'b0, 2'd2, 32'h40, 32'd0);
        idle(3);

        // Sub-word writes merge into an existing word
        send(1'b1, 2'd2, 32'h80, 32'h11223344);
        send(1'b1, 2'd0, 32'h81, 32'h0000AA00);
        send(1'b0, 2'd2, 32'h80, 32'd0);
        send(1'b1, 2'd1, 32'h82, 32'h55660000);
        send(1'b0, 2'd0, 32'h80, 32'd0);
        idle(4);

        // Back-to-back reads with req held high hit the full queue
        send(1'b0, 2'd2, 32'h40, 32'd0);
        send(1'b0, 2'd2, 32'h80, 32'd0);
        send(1'b0, 2'd3, 32'h40, 32'd0);
        idle(4);

        // Upper address bits alias onto the same word
        send(1'b1, 2'd2, 32'h0000_1004, 32'h12345678);
        send(1'b0, 2'd2, 32'h0000_0004, 32'd0);
        idle(3);

        // A write in flight at reset must never commit
        send(1'b1, 2'd2, 32'h10, 32'hCAFEF00D);
        reset_for(1);
        send(1'b1, 2'd2, 32'h10, 32'h00000001);
        send(1'b0, 2'd2, 32'h10, 32'd0);
        idle(4);

        for (int i = 0; i < 400; i++) begin
            a       = $urandom;
            a[11:2] = 10'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) begin
                apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 2'd0, a, 32'd0, acc);
            end else begin
                apply_stimulus(1'b0, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                               2'($urandom_range(0, 3)), a, $urandom, acc);
            end
        end

        drain = 0;
        while (sb.size() > 0 && drain < 20) begin
            idle(1);
            drain++;
        end
        check_output("drain_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_like_responder.md
SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-index bits, giving memory depth 2^ADDR_WIDTH words of 32 bits.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to data_ok; legal range 1..7.
REQ-003 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have req  input  1  initiator request valid.
REQ-006 SHALL have wr  input  1  1 = write, 0 = read.
REQ-007 SHALL have size  input  2  access size: 0 byte, 1 halfword, 2 word; 3 treated as word.
REQ-008 SHALL have addr  input  32  byte address.
REQ-009 SHALL have wdata  input  32  write data, byte lanes aligned to addr[1:0].
REQ-010 SHALL have rdata  output  32  read data, valid only while data_ok=1.
REQ-011 SHALL have addr_ok  output  1  request accepted this cycle.
REQ-012 SHALL have data_ok  output  1  oldest accepted request completes this cycle.

Function
REQ-013 SHALL hold accepted requests in an in-order pending queue of exactly 2 entries, each capturing wr, size, addr, wdata and a countdown.
REQ-014 SHALL drive addr_ok = req && queue not full, combinationally; no bypass, so a pop in the same cycle does not make a full queue accept.
REQ-015 SHALL treat acceptance as req && addr_ok in cycle T and push the entry at the end of cycle T.
REQ-016 SHALL assert data_ok for exactly one cycle per accepted request, no earlier than cycle T+LATENCY, in acceptance order, at most one per cycle.
REQ-017 SHALL complete a request in exactly cycle T+LATENCY when no older request is still pending in that cycle; otherwise in the cycle after the older request's data_ok.
REQ-018 SHALL pop the head at the end of its data_ok cycle.
REQ-019 SHALL index memory with addr[ADDR_WIDTH+1:2] and ignore higher address bits (wrap-around aliasing).
REQ-020 SHALL, for a read, drive rdata = full 32-bit memory word during data_ok regardless of size; initiator extracts lanes.
REQ-021 SHALL, for a write, update memory at the end of the data_ok cycle using byte enables: size 0 -> lane addr[1:0]; size 1 -> lanes {addr[1],0} and {addr[1],1}, addr[0] ignored; size 2/3 -> all four lanes.
REQ-022 SHALL drive rdata = 0 for a write completion and whenever data_ok=0.
REQ-023 SHALL make a write visible to any later-accepted read (in-order completion guarantees this; no forwarding needed).
REQ-024 SHALL ignore wr, size, addr and wdata when req=0 or addr_ok=0.
REQ-025 SHALL accept a new request in the same cycle another completes whenever the queue is not full at the start of that cycle.

Reset
REQ-026 SHALL, while rst=1, empty the queue, force data_ok=0, rdata=0, addr_ok=0.
REQ-027 SHALL, in the first cycle after rst falls, drive addr_ok = req (queue empty).
REQ-028 SHALL discard requests pending at reset: no data_ok is issued for them and their writes are not committed.
REQ-029 SHALL NOT clear memory contents on reset; contents are undefined until written.

Verification (LATENCY=2, ADDR_WIDTH=10)
REQ-030 Word write then read: write addr 0x40, wdata 0xDEADBEEF, size 2, accepted cycle 0 -> data_ok cycle 2, rdata 0; read 0x40 accepted cycle 3 -> data_ok cycle 5, rdata 0xDEADBEEF.
REQ-031 Sub-word write: word at 0x80 = 0x11223344; byte write addr 0x81, wdata 0x0000AA00 -> read returns 0x1122AA44; halfword write addr 0x82, wdata 0x55660000 -> read returns 0x5566AA44.
REQ-032 Back-pressure: req held high with three reads accepted cycles 0,1 -> addr_ok=0 in cycle 2 (full, head completing); third accepted cycle 3; data_ok in cycles 2, 3, 5, in order.
REQ-033 Aliasing: write 0x12345678 to addr 0x0000_1004 -> read of addr 0x0000_0004 returns 0x12345678.
REQ-034 Reset mid-operation: write 0xCAFEF00D to 0x10 accepted cycle 0, rst=1 in cycle 1 -> no data_ok; after reset, write 0x1 to 0x10 then read 0x10 returns 0x00000001, not 0xCAFEF00D.
